// File: rtl/prime_search_engine.sv
// rtl/prime_search_engine.sv - N-lane trial-division search for the nearest prime below/above an origin
// Optional feature macro: PRIME_CYCLE_CNT_EN adds the busy-cycle counter output 'cycles'.
module prime_search_engine #(
    parameter int WIDTH   = 32,
    parameter int N_LANES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode_up,
    input  logic [WIDTH-1:0]   start_val,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [WIDTH-1:0]   prime_val,
    output logic [WIDTH-1:0]   base,
    output logic [N_LANES-1:0] lane_done,
    output logic [N_LANES-1:0] lane_prime
`ifdef PRIME_CYCLE_CNT_EN
    ,
    output logic [31:0]        cycles
`endif
);

    typedef enum logic [2:0] {IDLE, DISPATCH, TEST, RESOLVE, FINISH} state_t;

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    state_t             state;
    logic               mode;
    logic [WIDTH-1:0]   cand [N_LANES];
    logic [WIDTH-1:0]   dvsr [N_LANES];
    logic [N_LANES-1:0] oor;

    logic [2*WIDTH-1:0] dsq [N_LANES];
    logic [N_LANES-1:0] divides;
    logic               sel_found;
    logic [WIDTH-1:0]   sel_val;
    logic               range_end;

    always_comb begin
        for (int i = 0; i < N_LANES; i++) begin
            dsq[i]     = {{WIDTH{1'b0}}, dvsr[i]} * {{WIDTH{1'b0}}, dvsr[i]};
            divides[i] = (dvsr[i] != '0) && ((cand[i] % dvsr[i]) == '0);
        end
    end

    // Scan from the top so the lowest-index (closest to origin) prime wins.
    always_comb begin
        sel_found = 1'b0;
        sel_val   = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (lane_prime[i]) begin
                sel_found = 1'b1;
                sel_val   = cand[i];
            end
        end
        range_end = (|oor) ||
                    (mode ? (cand[N_LANES-1] == MAX_VAL) : (cand[N_LANES-1] < WIDTH'(2)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mode       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            prime_val  <= '0;
            base       <= '0;
            lane_done  <= '0;
            lane_prime <= '0;
            oor        <= '0;
            for (int i = 0; i < N_LANES; i++) begin
                cand[i] <= '0;
                dvsr[i] <= '0;
            end
`ifdef PRIME_CYCLE_CNT_EN
            cycles     <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef PRIME_CYCLE_CNT_EN
            if (state == IDLE && start)
                cycles <= '0;
            else if (busy && cycles != 32'hFFFF_FFFF)
                cycles <= cycles + 32'd1;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        mode  <= mode_up;
                        base  <= start_val;
                        found <= 1'b0;
                        busy  <= 1'b1;
                        state <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    for (int i = 0; i < N_LANES; i++) begin
                        if (mode) begin
                            cand[i] <= base + WIDTH'(i);
                            oor[i]  <= base > (MAX_VAL - WIDTH'(i));
                        end else begin
                            cand[i] <= base - WIDTH'(i);
                            oor[i]  <= base < WIDTH'(i);
                        end
                        dvsr[i] <= WIDTH'(3);
                    end
                    lane_done  <= '0;
                    lane_prime <= '0;
                    state      <= TEST;
                end
                TEST: begin
                    if (&lane_done) begin
                        state <= RESOLVE;
                    end else begin
                        for (int i = 0; i < N_LANES; i++) begin
                            if (!lane_done[i]) begin
                                if (oor[i] || cand[i] < WIDTH'(2)) begin
                                    lane_done[i] <= 1'b1;
                                end else if (cand[i] == WIDTH'(2) || cand[i] == WIDTH'(3)) begin
                                    lane_done[i]  <= 1'b1;
                                    lane_prime[i] <= 1'b1;
                                end else if (!cand[i][0]) begin
                                    lane_done[i] <= 1'b1;
                                end else if (dsq[i] > {{WIDTH{1'b0}}, cand[i]}) begin
                                    lane_done[i]  <= 1'b1;
                                    lane_prime[i] <= 1'b1;
                                end else if (divides[i]) begin
                                    lane_done[i] <= 1'b1;
                                end else begin
                                    dvsr[i] <= dvsr[i] + WIDTH'(2);
                                end
                            end
                        end
                    end
                end
                RESOLVE: begin
                    if (sel_found) begin
                        found     <= 1'b1;
                        prime_val <= sel_val;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= FINISH;
                    end else if (range_end) begin
                        found <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        base  <= mode ? base + WIDTH'(N_LANES) : base - WIDTH'(N_LANES);
                        state <= DISPATCH;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prime_search_engine.sv
// tb/tb_prime_search_engine.sv - directed checks of prime_search_engine at 32/8 and 8/4 configurations
module tb_prime_search_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_start = 1'b0, a_up = 1'b0;
    logic [31:0] a_val = '0;
    logic        a_busy, a_done, a_found;
    logic [31:0] a_prime, a_base;
    logic [7:0]  a_ldone, a_lprime;

    logic        b_start = 1'b0, b_up = 1'b0;
    logic [7:0]  b_val = '0;
    logic        b_busy, b_done, b_found;
    logic [7:0]  b_prime, b_base;
    logic [3:0]  b_ldone, b_lprime;
`ifdef PRIME_CYCLE_CNT_EN
    logic [31:0] a_cycles, b_cycles;
`endif

    int vec_cnt = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    prime_search_engine #(.WIDTH(32), .N_LANES(8)) u_w32 (
        .clk(clk), .rst(rst), .start(a_start), .mode_up(a_up), .start_val(a_val),
        .busy(a_busy), .done(a_done), .found(a_found), .prime_val(a_prime),
        .base(a_base), .lane_done(a_ldone), .lane_prime(a_lprime)
`ifdef PRIME_CYCLE_CNT_EN
        , .cycles(a_cycles)
`endif
    );

    prime_search_engine #(.WIDTH(8), .N_LANES(4)) u_w8 (
        .clk(clk), .rst(rst), .start(b_start), .mode_up(b_up), .start_val(b_val),
        .busy(b_busy), .done(b_done), .found(b_found), .prime_val(b_prime),
        .base(b_base), .lane_done(b_ldone), .lane_prime(b_lprime)
`ifdef PRIME_CYCLE_CNT_EN
        , .cycles(b_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run(input bit w8, input logic [31:0] sv, input logic up,
                       input logic exp_found, input logic [31:0] exp_val, input string tag);
        int  busy_n;
        bit  seen;
        logic obs_busy, obs_done, obs_found;
        logic [31:0] obs_prime, obs_cycles;
        @(negedge clk);
        if (w8) begin b_start = 1'b1; b_val = sv[7:0]; b_up = up; end
        else    begin a_start = 1'b1; a_val = sv;      a_up = up; end
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
        busy_n = 0;
        seen = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            obs_busy = w8 ? b_busy : a_busy;
            obs_done = w8 ? b_done : a_done;
            if (obs_busy) busy_n++;
            if (obs_done) seen = 1'b1;
            else @(negedge clk);
        end
        obs_found  = w8 ? b_found : a_found;
        obs_prime  = w8 ? {24'd0, b_prime} : a_prime;
        obs_cycles = 32'(busy_n);
`ifdef PRIME_CYCLE_CNT_EN
        obs_cycles = w8 ? b_cycles : a_cycles;
`endif
        chk({tag, "_done"}, seen, 1);
        chk({tag, "_found"}, obs_found, exp_found);
        chk({tag, "_prime"}, obs_prime, exp_val);
        chk({tag, "_busy_low"}, w8 ? b_busy : a_busy, 0);
        chk({tag, "_cycles"}, obs_cycles, busy_n);
        @(negedge clk);
        chk({tag, "_pulse"}, w8 ? b_done : a_done, 0);
    endtask

    initial begin
        int dn;
        repeat (2) @(negedge clk);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_found", a_found, 0);
        chk("rst_prime", a_prime, 0);
        chk("rst_lanes", {a_ldone, a_lprime}, 0);
        rst = 1'b0;

        run(0, 1000, 0, 1, 997,  "dn1000");
        run(0, 1164, 0, 1, 1163, "dn1164");
        run(0, 1000, 1, 1, 1009, "up1000");
        run(0, 2,    0, 1, 2,    "dn2");
        run(0, 1,    0, 0, 2,    "dn1");
        run(0, 0,    1, 1, 2,    "up0");

        // Start held every cycle while busy: only the first request counts.
        @(negedge clk);
        a_start = 1'b1; a_val = 1000; a_up = 1'b0;
        dn = 0;
        for (int c = 0; c < 400 && dn == 0; c++) begin
            @(negedge clk);
            a_val = 32'(50 + c);
            a_up = 1'b1;
            if (a_done) begin
                dn++;
                a_start = 1'b0;
            end
        end
        chk("spam_prime", a_prime, 997);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (a_done) dn++;
        end
        chk("spam_one_done", dn, 1);

        // Reset in the middle of a search.
        @(negedge clk);
        a_start = 1'b1; a_val = 1000; a_up = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", a_busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_busy", a_busy, 0);
        chk("mrst_found", a_found, 0);
        chk("mrst_prime", a_prime, 0);
        chk("mrst_base", a_base, 0);
        chk("mrst_lanes", {a_ldone, a_lprime}, 0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (a_done || a_busy) dn++;
        end
        chk("mrst_quiet", dn, 0);

        run(1, 250, 0, 1, 241, "w8_dn250");
        run(1, 252, 1, 0, 241, "w8_up252");
        run(1, 2,   1, 1, 2,   "w8_up2");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
